// File: rtl/wb_region_router.sv
// Wishbone pipelined router: decodes the core address into one of NUM_REGIONS
// windows (or an internal error target) and steers requests/responses.

module wb_region_dec (
  input  logic [31:0] adr_i,
  input  logic [31:0] base_i,
  input  logic [31:0] size_i,
  output logic        hit_o,
  output logic [31:0] off_o
);
  logic [32:0] end_excl;

  // 33-bit end keeps a window touching 2^32 from wrapping around to zero
  assign end_excl = {1'b0, base_i} + {1'b0, size_i};
  assign hit_o    = (size_i != '0) && (adr_i >= base_i) && ({1'b0, adr_i} < end_excl);
  assign off_o    = adr_i - base_i;
endmodule

module wb_region_router #(
  parameter int          NUM_REGIONS = 4,
  parameter int          MAX_OUTST   = 4,
  parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      core_wb_cyc_i,
  input  logic                      core_wb_stb_i,
  input  logic                      core_wb_we_i,
  input  logic [31:0]               core_wb_adr_i,
  input  logic [31:0]               core_wb_dat_i,
  input  logic [3:0]                core_wb_sel_i,
  output logic                      core_wb_stall_o,
  output logic                      core_wb_ack_o,
  output logic                      core_wb_err_o,
  output logic [31:0]               core_wb_dat_o,
  input  logic [32*NUM_REGIONS-1:0] region_base_i,
  input  logic [32*NUM_REGIONS-1:0] region_size_i,
  output logic [NUM_REGIONS-1:0]    rg_wb_cyc_o,
  output logic [NUM_REGIONS-1:0]    rg_wb_stb_o,
  output logic [NUM_REGIONS-1:0]    rg_wb_we_o,
  output logic [32*NUM_REGIONS-1:0] rg_wb_adr_o,
  output logic [32*NUM_REGIONS-1:0] rg_wb_dat_o,
  output logic [4*NUM_REGIONS-1:0]  rg_wb_sel_o,
  input  logic [NUM_REGIONS-1:0]    rg_wb_stall_i,
  input  logic [NUM_REGIONS-1:0]    rg_wb_ack_i,
  input  logic [NUM_REGIONS-1:0]    rg_wb_err_i,
  input  logic [32*NUM_REGIONS-1:0] rg_wb_dat_i,
  output logic [3:0]                outst_o,
  output logic                      unmapped_o
);
  localparam int             TW  = $clog2(NUM_REGIONS + 1);
  localparam logic [TW-1:0]  ERR = TW'(NUM_REGIONS);

  logic [NUM_REGIONS-1:0]         hit;
  logic [NUM_REGIONS-1:0][31:0]   off;

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_dec
    wb_region_dec u_dec (
      .adr_i  (core_wb_adr_i),
      .base_i (region_base_i[32*g +: 32]),
      .size_i (region_size_i[32*g +: 32]),
      .hit_o  (hit[g]),
      .off_o  (off[g])
    );
  end

  logic [TW-1:0] target;

  // descending scan so the lowest matching region wins
  always_comb begin
    target = ERR;
    for (int k = NUM_REGIONS - 1; k >= 0; k--)
      if (hit[k]) target = TW'(k);
  end

  logic [3:0]    outst_q, outst_d;
  logic [TW-1:0] cur_tgt_q, cur_tgt_d;
  logic          err_pend_q, err_pend_d;

  logic        tgt_stall, sel_ack, sel_err;
  logic [31:0] sel_dat;

  always_comb begin
    tgt_stall = 1'b0;
    sel_ack   = 1'b0;
    sel_err   = 1'b0;
    sel_dat   = '0;
    for (int k = 0; k < NUM_REGIONS; k++) begin
      if (target == TW'(k)) tgt_stall = rg_wb_stall_i[k];
      if (cur_tgt_q == TW'(k)) begin
        sel_ack = rg_wb_ack_i[k];
        sel_err = rg_wb_err_i[k];
        sel_dat = rg_wb_dat_i[32*k +: 32];
      end
    end
  end

  logic req, busy, blk, stall, accept, live, rsp_rg, rsp_int, rsp, abort;

  assign req     = core_wb_cyc_i & core_wb_stb_i;
  assign busy    = (outst_q != '0);
  assign blk     = (outst_q == 4'(MAX_OUTST)) | (busy & (target != cur_tgt_q));
  assign stall   = req & (blk | tgt_stall);
  assign accept  = req & ~stall;
  // a master that has dropped cyc no longer owns any response
  assign live    = core_wb_cyc_i & busy;
  assign rsp_rg  = live & (sel_ack | sel_err);
  assign rsp_int = live & err_pend_q;
  assign rsp     = rsp_rg | rsp_int;
  assign abort   = ~core_wb_cyc_i & busy;

  always_comb begin
    outst_d    = outst_q;
    cur_tgt_d  = cur_tgt_q;
    err_pend_d = 1'b0;
    if (abort) begin
      outst_d   = '0;
      cur_tgt_d = '0;
    end else begin
      if (accept && !rsp)      outst_d = outst_q + 4'd1;
      else if (!accept && rsp) outst_d = outst_q - 4'd1;
      if (accept) cur_tgt_d = target;
      err_pend_d = accept & (target == ERR);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outst_q    <= '0;
      cur_tgt_q  <= '0;
      err_pend_q <= 1'b0;
    end else begin
      outst_q    <= outst_d;
      cur_tgt_q  <= cur_tgt_d;
      err_pend_q <= err_pend_d;
    end
  end

  // everything is gated by rst_n so outputs clear the instant reset asserts
  always_comb begin
    core_wb_stall_o = rst_n & stall;
    core_wb_ack_o   = rst_n & rsp_rg & ~sel_err;
    core_wb_err_o   = rst_n & (rsp_int | (rsp_rg & sel_err));
    core_wb_dat_o   = '0;
    if (rst_n && rsp_int)     core_wb_dat_o = ERR_DATA;
    else if (rst_n && rsp_rg) core_wb_dat_o = sel_dat;
    unmapped_o      = rst_n & accept & (target == ERR);
    outst_o         = outst_q;

    rg_wb_cyc_o = '0;
    rg_wb_stb_o = '0;
    rg_wb_we_o  = '0;
    rg_wb_adr_o = '0;
    rg_wb_dat_o = '0;
    rg_wb_sel_o = '0;
    if (rst_n) begin
      for (int k = 0; k < NUM_REGIONS; k++) begin
        rg_wb_cyc_o[k] = core_wb_cyc_i & ((target == TW'(k)) | (busy & (cur_tgt_q == TW'(k))));
        if (target == TW'(k)) begin
          rg_wb_stb_o[k]            = core_wb_stb_i & ~blk;
          rg_wb_we_o[k]             = core_wb_we_i;
          rg_wb_adr_o[32*k +: 32]   = off[k];
          rg_wb_dat_o[32*k +: 32]   = core_wb_dat_i;
          rg_wb_sel_o[4*k +: 4]     = core_wb_sel_i;
        end
      end
    end
  end
endmodule

// File: tb/tb_wb_region_router.sv
// Randomized and directed checks of wb_region_router against a queue-based
// transaction model of the routing rules.

module tb_wb_region_router;
  localparam int          NR   = 4;
  localparam int          MAXO = 4;
  localparam logic [31:0] ERRD = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic rst_n;
  logic core_wb_cyc_i, core_wb_stb_i, core_wb_we_i;
  logic [31:0] core_wb_adr_i, core_wb_dat_i;
  logic [3:0]  core_wb_sel_i;
  logic core_wb_stall_o, core_wb_ack_o, core_wb_err_o;
  logic [31:0] core_wb_dat_o;
  logic [32*NR-1:0] region_base_i, region_size_i;
  logic [NR-1:0] rg_wb_cyc_o, rg_wb_stb_o, rg_wb_we_o;
  logic [32*NR-1:0] rg_wb_adr_o, rg_wb_dat_o;
  logic [4*NR-1:0] rg_wb_sel_o;
  logic [NR-1:0] rg_wb_stall_i, rg_wb_ack_i, rg_wb_err_i;
  logic [32*NR-1:0] rg_wb_dat_i;
  logic [3:0] outst_o;
  logic unmapped_o;

  logic [31:0] base [NR];
  logic [31:0] size [NR];
  logic [31:0] sdat [NR];

  always #5 clk = ~clk;

  always_comb begin
    region_base_i = '0;
    region_size_i = '0;
    rg_wb_dat_i   = '0;
    for (int k = 0; k < NR; k++) begin
      region_base_i[32*k +: 32] = base[k];
      region_size_i[32*k +: 32] = size[k];
      rg_wb_dat_i[32*k +: 32]   = sdat[k];
    end
  end

  wb_region_router #(.NUM_REGIONS(NR), .MAX_OUTST(MAXO), .ERR_DATA(ERRD)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_wb_cyc_i(core_wb_cyc_i), .core_wb_stb_i(core_wb_stb_i), .core_wb_we_i(core_wb_we_i),
    .core_wb_adr_i(core_wb_adr_i), .core_wb_dat_i(core_wb_dat_i), .core_wb_sel_i(core_wb_sel_i),
    .core_wb_stall_o(core_wb_stall_o), .core_wb_ack_o(core_wb_ack_o), .core_wb_err_o(core_wb_err_o),
    .core_wb_dat_o(core_wb_dat_o), .region_base_i(region_base_i), .region_size_i(region_size_i),
    .rg_wb_cyc_o(rg_wb_cyc_o), .rg_wb_stb_o(rg_wb_stb_o), .rg_wb_we_o(rg_wb_we_o),
    .rg_wb_adr_o(rg_wb_adr_o), .rg_wb_dat_o(rg_wb_dat_o), .rg_wb_sel_o(rg_wb_sel_o),
    .rg_wb_stall_i(rg_wb_stall_i), .rg_wb_ack_i(rg_wb_ack_i), .rg_wb_err_i(rg_wb_err_i),
    .rg_wb_dat_i(rg_wb_dat_i), .outst_o(outst_o), .unmapped_o(unmapped_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // model: one queue entry per accepted-but-unanswered transaction (its target)
  int pend_q[$];
  int m_cur;
  bit err_due;
  bit m_acc, m_resp;
  int m_tgt;

  function automatic int find_tgt(input logic [31:0] a);
    for (int k = 0; k < NR; k++)
      if (size[k] != 0 && 64'(a) >= 64'(base[k]) && 64'(a) < 64'(base[k]) + 64'(size[k]))
        return k;
    return NR;
  endfunction

  task automatic model_clear();
    pend_q.delete();
    m_cur   = 0;
    err_due = 0;
  endtask

  task automatic compare_all();
    int n;
    bit blk, e_stall;
    logic e_ack, e_err;
    logic [31:0] e_dat;
    logic [NR-1:0] e_cyc, e_stb, e_we;
    logic [32*NR-1:0] e_adr, e_dat_o;
    logic [4*NR-1:0] e_sel;
    n     = pend_q.size();
    m_tgt = find_tgt(core_wb_adr_i);
    blk   = (n == MAXO) || (n != 0 && m_tgt != m_cur);
    e_stall = core_wb_cyc_i && core_wb_stb_i && (blk || (m_tgt != NR && rg_wb_stall_i[m_tgt]));
    m_acc = core_wb_cyc_i && core_wb_stb_i && !e_stall;
    m_resp = 0; e_ack = 0; e_err = 0; e_dat = 0;
    if (core_wb_cyc_i && n != 0) begin
      if (m_cur == NR) begin
        if (err_due) begin m_resp = 1; e_err = 1; e_dat = ERRD; end
      end else if (rg_wb_ack_i[m_cur] || rg_wb_err_i[m_cur]) begin
        m_resp = 1;
        e_err  = rg_wb_err_i[m_cur];
        e_ack  = !e_err;
        e_dat  = sdat[m_cur];
      end
    end
    e_cyc = '0; e_stb = '0; e_we = '0; e_adr = '0; e_dat_o = '0; e_sel = '0;
    for (int k = 0; k < NR; k++) begin
      e_cyc[k] = core_wb_cyc_i && (k == m_tgt || (n != 0 && k == m_cur));
      if (k == m_tgt) begin
        e_stb[k]            = core_wb_stb_i && !blk;
        e_we[k]             = core_wb_we_i;
        e_adr[32*k +: 32]   = core_wb_adr_i - base[k];
        e_dat_o[32*k +: 32] = core_wb_dat_i;
        e_sel[4*k +: 4]     = core_wb_sel_i;
      end
    end
    chk("stall", core_wb_stall_o, e_stall);
    chk("ack", core_wb_ack_o, e_ack);
    chk("err", core_wb_err_o, e_err);
    chk("rdat", core_wb_dat_o, e_dat);
    chk("unmapped", unmapped_o, m_acc && m_tgt == NR);
    chk("outst", outst_o, 4'(n));
    chk("rg_cyc", rg_wb_cyc_o, e_cyc);
    chk("rg_stb", rg_wb_stb_o, e_stb);
    chk("rg_we", rg_wb_we_o, e_we);
    chk("rg_adr", rg_wb_adr_o, e_adr);
    chk("rg_wdat", rg_wb_dat_o, e_dat_o);
    chk("rg_sel", rg_wb_sel_o, e_sel);
  endtask

  task automatic settle();
    #2;
    compare_all();
  endtask

  task automatic adv();
    @(posedge clk);
    if (!core_wb_cyc_i && pend_q.size() != 0) model_clear();
    else begin
      if (m_resp) void'(pend_q.pop_front());
      if (m_acc) begin pend_q.push_back(m_tgt); m_cur = m_tgt; end
      err_due = m_acc && (m_tgt == NR);
    end
    #1;
  endtask

  task automatic quiet();
    core_wb_stb_i = 0; core_wb_we_i = 0;
    core_wb_adr_i = 0; core_wb_dat_i = 0; core_wb_sel_i = 0;
    rg_wb_stall_i = '0; rg_wb_ack_i = '0; rg_wb_err_i = '0;
  endtask

  task automatic req(input logic [31:0] a);
    core_wb_cyc_i = 1; core_wb_stb_i = 1; core_wb_we_i = 0;
    core_wb_adr_i = a; core_wb_sel_i = 4'hF; core_wb_dat_i = $urandom;
  endtask

  // ack the current target each cycle until the model is idle
  task automatic drain(input string tag);
    int i;
    for (i = 0; i < 12 && pend_q.size() != 0; i++) begin
      quiet();
      rg_wb_ack_i = '1;
      for (int k = 0; k < NR; k++) sdat[k] = $urandom;
      settle(); adv();
    end
    chk({tag, "_drain_bound"}, (i < 12), 1'b1);
    quiet();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_core"}, {core_wb_stall_o, core_wb_ack_o, core_wb_err_o, core_wb_dat_o, unmapped_o, outst_o}, '0);
    chk({tag, "_rgctl"}, {rg_wb_cyc_o, rg_wb_stb_o, rg_wb_we_o, rg_wb_sel_o}, '0);
    chk({tag, "_rgbus"}, rg_wb_adr_o | rg_wb_dat_o, '0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    base[0] = 32'h8000_0000; size[0] = 32'h1000;
    base[1] = 32'h8000_1000; size[1] = 32'h1_0000;
    base[2] = 32'h8002_0000; size[2] = 32'h100;
    base[3] = 32'h0;         size[3] = 32'h0;
    for (int k = 0; k < NR; k++) sdat[k] = 0;
    rst_n = 0; core_wb_cyc_i = 0; quiet(); model_clear();
    #2; chk_zero("rst_idle");
    req(32'h8000_0000); #1; chk_zero("rst_req");
    @(posedge clk); #1;
    core_wb_cyc_i = 0; quiet(); rst_n = 1;

    // region boundary and offset
    req(32'h8000_0FFC); settle();
    chk("r26_stb_a", rg_wb_stb_o, 4'b0001);
    chk("r26_adr_a", rg_wb_adr_o[31:0], 32'hFFC);
    adv(); drain("r26a");
    req(32'h8000_1000); settle();
    chk("r26_stb_b", rg_wb_stb_o, 4'b0010);
    chk("r26_adr_b", rg_wb_adr_o[63:32], 32'h0);
    adv(); drain("r26b");

    // overlapping windows
    size[0] = 32'h2000;
    req(32'h8000_1800); settle();
    chk("r27_stb", rg_wb_stb_o, 4'b0001);
    chk("r27_adr", rg_wb_adr_o[31:0], 32'h1800);
    adv(); drain("r27");
    size[0] = 32'h1000;

    // unmapped access
    req(32'h0000_0010); settle();
    chk("r30_unm", unmapped_o, 1'b1);
    adv(); quiet(); settle();
    chk("r30_err", core_wb_err_o, 1'b1);
    chk("r30_dat", core_wb_dat_o, ERRD);
    adv(); settle();
    chk("r30_idle", outst_o, 4'd0);
    adv();

    // pipeline fill to MAX_OUTST
    for (int i = 0; i < 5; i++) begin
      req(32'h8000_1000 + 32'(4*i)); settle();
      if (i == 4) chk("r28_stall5", core_wb_stall_o, 1'b1);
      adv();
      if (i < 4) chk("r28_outst", outst_o, 4'(i + 1));
    end
    rg_wb_ack_i = 4'b0010; sdat[1] = 32'hA0; settle();
    chk("r28_ack1", core_wb_dat_o, 32'hA0);
    adv(); rg_wb_ack_i = '0; settle();
    chk("r28_accept5", core_wb_stall_o, 1'b0);
    adv(); drain("r28");

    // target switch waits for drain
    req(32'h8000_0000); settle(); adv();
    req(32'h8000_1000); settle();
    chk("r29_stall", core_wb_stall_o, 1'b1);
    adv(); rg_wb_ack_i = 4'b0001; settle(); adv();
    rg_wb_ack_i = '0; settle();
    chk("r29_go", core_wb_stall_o, 1'b0);
    adv(); drain("r29");

    // abort with requests outstanding
    req(32'h8000_1000); settle(); adv();
    req(32'h8000_1004); settle(); adv();
    chk("r31_two", outst_o, 4'd2);
    core_wb_cyc_i = 0; quiet(); settle(); adv();
    core_wb_cyc_i = 1; rg_wb_ack_i = 4'b0010; settle();
    chk("r31_late", core_wb_ack_o, 1'b0);
    adv(); quiet();

    // reset mid-burst
    req(32'h8000_1000); settle(); adv();
    settle(); adv();
    rst_n = 0; #1; chk_zero("rst_mid");
    model_clear();
    @(posedge clk); #1; rst_n = 1;
    core_wb_cyc_i = 1; quiet(); rg_wb_ack_i = 4'b0010; settle(); adv();
    quiet();

    for (int c = 0; c < 3000; c++) begin
      int k;
      k = $urandom_range(NR - 1, 0);
      core_wb_cyc_i = ($urandom % 12) != 0;
      core_wb_stb_i = ($urandom % 10) < 7;
      core_wb_we_i  = $urandom;
      core_wb_dat_i = $urandom;
      core_wb_sel_i = $urandom;
      case ($urandom % 6)
        0: core_wb_adr_i = base[k];
        1: core_wb_adr_i = base[k] + size[k] - 1;
        2: core_wb_adr_i = base[k] + size[k];
        3: core_wb_adr_i = base[k] + ($urandom % (size[k] + 1));
        4: core_wb_adr_i = 32'h10;
        default: core_wb_adr_i = $urandom;
      endcase
      for (int j = 0; j < NR; j++) begin
        rg_wb_stall_i[j] = ($urandom % 5) == 0;
        rg_wb_ack_i[j]   = ($urandom % 3) == 0;
        rg_wb_err_i[j]   = ($urandom % 8) == 0;
        sdat[j]          = $urandom;
      end
      settle(); adv();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
